prv32_mdu: RTL

Parametrised multi-cycle multiply/divide unit implementing the RV32M funct3 operations. It is the sequential companion to the single-cycle ALU in the execute stage. It takes operands through a valid/ready handshake, iterates one bit per cycle, and holds the result until the consumer accepts it. It adds signed/unsigned high-half multiply, divide and remainder, the RISC-V corner-case results, back-pressure and pipeline flush.

---
 rtl/prv32_mdu_pkg.sv | 38 +++
 rtl/prv32_mdu_step.sv | 31 +++
 rtl/prv32_mdu.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/prv32_mdu_pkg.sv
// Shared encodings and helpers for the RV32M multiply/divide unit.
package prv32_mdu_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Operation context captured at accept time.
  typedef struct packed {
    logic [2:0] f3;
    logic       neg_quo;
    logic       neg_rem;
  } op_t;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic op_a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/prv32_mdu_step.sv
// One shift-add multiply or restoring-divide iteration on magnitudes.
// Purely combinational; the caller registers acc_o each cycle.
module prv32_mdu_step #(
  parameter int XLEN = 32
) (
  input  logic                div_i,
  input  logic [2*XLEN-1:0]   acc_i,
  input  logic [XLEN-1:0]     opnd_i,
  output logic [2*XLEN-1:0]   acc_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shl;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    // Multiply: {hi, multiplier} -- add multiplicand on the low bit, then shift right.
    sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Divide: {remainder, dividend/quotient} -- shift left and trial-subtract.
    shl  = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    ge   = (shl >= {1'b0, opnd_i});
    diff = shl[XLEN-1:0] - opnd_i;
    if (div_i) begin
      acc_o = {(ge ? diff : shl[XLEN-1:0]), acc_i[XLEN-2:0], ge};
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/prv32_mdu.sv
// Multi-cycle RV32M multiply/divide: XLEN+1 cycles per op, 1 cycle for div-by-zero/overflow.
// Result held with out_valid until out_ready; in_ready only in IDLE; flush kills any op.
module prv32_mdu
  import prv32_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN);
  localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  op_t                 op_q, op_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;

  logic [2*XLEN-1:0]   step_acc;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo, rem, a_mag, b_mag;
  logic                a_neg, b_neg;

  prv32_mdu_step #(.XLEN(XLEN)) u_step (
    .div_i  (is_div(op_q.f3)),
    .acc_i  (acc_q),
    .opnd_i (opb_q),
    .acc_o  (step_acc)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opb_d       = opb_q;
    op_d        = op_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    a_neg = op_a_signed(funct3) && a[XLEN-1];
    b_neg = op_b_signed(funct3) && b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;

    prod = op_q.neg_quo ? -acc_q : acc_q;
    quo  = op_q.neg_quo ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = op_q.neg_rem ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d    = S_CALC;
          in_ready_d = 1'b0;
          cnt_d      = '0;
          opb_d      = b_mag;
          acc_d      = {{XLEN{1'b0}}, a_mag};
          op_d       = '{f3: funct3, neg_quo: a_neg ^ b_neg, neg_rem: a_neg};
          // Corner cases preload the final quotient/remainder and jump to fix-up.
          if (is_div(funct3) && (b == '0)) begin
            acc_d = {a, {XLEN{1'b1}}};
            op_d  = '{f3: funct3, neg_quo: 1'b0, neg_rem: 1'b0};
            cnt_d = LAST;
          end else if ((funct3 == F3_DIV || funct3 == F3_REM) && a == MIN_NEG && b == '1) begin
            acc_d = {{XLEN{1'b0}}, a};
            op_d  = '{f3: funct3, neg_quo: 1'b0, neg_rem: 1'b0};
            cnt_d = LAST;
          end
        end
      end
      S_CALC: begin
        if (cnt_q == LAST) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          if (op_q.f3 == F3_REM || op_q.f3 == F3_REMU) begin
            result_d = rem;
          end else if (op_q.f3 == F3_DIV || op_q.f3 == F3_DIVU) begin
            result_d = quo;
          end else if (op_q.f3 == F3_MUL) begin
            result_d = prod[XLEN-1:0];
          end else begin
            result_d = prod[2*XLEN-1:XLEN];
          end
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase

    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opb_q       <= '0;
      op_q        <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opb_q       <= opb_d;
      op_q        <= op_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule
